rpsc_input_filter: RTL and testbench
====================================

Name: rpsc_input_filter

Overview:
- Input-conditioning stage ahead of the RPSC card-3 interlock logic.
- Synchronises raw field/status lines into the clk domain and applies a digital low-pass (asymmetric debounce) per channel.
- Provides qualified levels, edge pulses and sticky glitch flags. Card logic consumes the qualified levels (e.g. G2_PS_ACT, DR_AMP) instead of raw pins.
- One instance per card; channel count set by parameter.

Parameters:
NCH, 4, number of independent input channels.
SYNC_STAGES, 2, synchroniser flip-flop depth (legal 2..4).
ON_COUNT, 128, consecutive synced-high cycles required to assert a filtered output (legal 1..2^CNT_W-1).
OFF_COUNT, 16, consecutive synced-low cycles required to deassert a filtered output (legal 1..2^CNT_W-1).
CNT_W, 8, qualification counter width.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
raw_in  input  NCH  unsynchronised raw input lines, bit k = channel k.
clr_glitch  input  1  synchronous clear of all glitch flags.
filt_out  output  NCH  qualified (debounced) level per channel.
rise_pulse  output  NCH  one-cycle pulse when filt_out[k] goes 0->1.
fall_pulse  output  NCH  one-cycle pulse when filt_out[k] goes 1->0.
glitch_flag  output  NCH  sticky: a qualification was aborted on channel k.
any_glitch  output  1  OR of glitch_flag.

Behaviour:
- reset (asynchronous, active-low): all synchroniser stages, counters, filt_out, rise_pulse, fall_pulse, glitch_flag and any_glitch are forced to 0. Every channel's FSM goes to LOW. Deassertion is taken on the next clk edge.
- Synchroniser: s[k] is raw_in[k] delayed by SYNC_STAGES flops. Filtering acts only on s[k].
- Per-channel FSM, states LOW, RISE_QUAL, HIGH, FALL_QUAL. Counter cnt is CNT_W bits, 0 in LOW and HIGH.
  - LOW:
    - s=1 and ON_COUNT==1: go to HIGH.
    - s=1 and ON_COUNT>1: cnt<=1, go to RISE_QUAL.
    - s=0: stay.
  - RISE_QUAL:
    - s=0: go to LOW, cnt<=0, set glitch_flag[k].
    - s=1 and cnt==ON_COUNT-1: go to HIGH, cnt<=0.
    - otherwise: cnt<=cnt+1.
  - HIGH / FALL_QUAL: mirror of LOW / RISE_QUAL with s inverted and OFF_COUNT. An abort in FALL_QUAL (s=1) returns to HIGH and sets glitch_flag[k].
- Outputs are registered:
  - filt_out[k]=1 exactly in HIGH and FALL_QUAL.
  - rise_pulse[k] is high for exactly the one cycle in which filt_out[k] first reads 1; fall_pulse[k] likewise for the first cycle it reads 0.
- Latency:
  - A clean raw rise held long enough makes filt_out rise SYNC_STAGES+ON_COUNT clk edges after the edge that first samples raw_in=1.
  - A clean fall takes SYNC_STAGES+OFF_COUNT edges.
- Pulse widths:
  - A high pulse on s shorter than ON_COUNT cycles never reaches filt_out.
  - A high pulse of exactly ON_COUNT cycles does propagate.
- Counter: never wraps. The compare-to-limit transition happens before any increment past ON_COUNT-1 / OFF_COUNT-1.
- Glitch flags:
  - glitch_flag[k] is set on the cycle after the abort and stays set until clr_glitch=1 is sampled.
  - If clr_glitch and a new abort occur on the same edge, the set wins (flag stays 1).
  - any_glitch is registered together with glitch_flag, with the same timing.
- Channels are fully independent; simultaneous transitions on several channels are each handled in the same cycle.
- reset asserted mid-qualification: state is discarded. After release, a channel whose s is already 1 requires a full ON_COUNT qualification again, and no fall_pulse is generated by reset.
- Parameter legality (ON_COUNT, OFF_COUNT fit in CNT_W; SYNC_STAGES in range) is checked at elaboration; an illegal value is a fatal error.

Test Plan:
- Run all tests with NCH=4, SYNC_STAGES=2, ON_COUNT=16, OFF_COUNT=8.
- Reset/idle: reset=0 for 3 cycles with raw_in=4'b1111 -> all outputs 0. Release reset -> filt_out=4'b1111 exactly 18 edges later, with one rise_pulse per channel and glitch_flag=0.
- Rise/fall latency: raw_in[0] 0->1, held 40 cycles, then 1->0 -> filt_out[0] rises at edge 18 and falls 10 edges after the fall is sampled. One rise_pulse[0] and one fall_pulse[0] are seen; other channels stay quiet.
- Glitch rejection: raw_in[1] high for 10 cycles, then low -> filt_out[1] stays 0, glitch_flag[1]=1, any_glitch=1. Pulse clr_glitch -> both flags 0 the next cycle.
- Boundary pulse: raw_in[2] high for exactly 16 cycles -> filt_out[2] asserts. Then a low pulse of 7 cycles -> filt_out[2] stays 1 and glitch_flag[2] sets. Then a low pulse of 8 cycles -> filt_out[2] falls.
- Set-vs-clear collision: align an abort on channel 3 with clr_glitch=1 on the same edge -> glitch_flag[3]=1 afterwards.
- Mid-qualification reset: raw_in[0]=1 for 10 cycles, assert reset for 1 cycle, keep raw_in[0]=1 -> filt_out[0] asserts 18 edges after reset release. No glitch flag, no fall_pulse.

Source files
------------

// File: rtl/rpsc_input_filter.sv
// rpsc_input_filter: raw line synchroniser plus per-channel asymmetric
// debounce, with edge pulses and sticky glitch flags.
module rpsc_input_filter #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ON_COUNT    = 128,
  parameter int OFF_COUNT   = 16,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] raw_in,
  input  logic           clr_glitch,
  output logic [NCH-1:0] filt_out,
  output logic [NCH-1:0] rise_pulse,
  output logic [NCH-1:0] fall_pulse,
  output logic [NCH-1:0] glitch_flag,
  output logic           any_glitch
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "rpsc_input_filter: SYNC_STAGES must be 2..4");
  end
  if (ON_COUNT < 1 || ON_COUNT > (2**CNT_W) - 1) begin : g_bad_on
    $fatal(1, "rpsc_input_filter: ON_COUNT does not fit CNT_W");
  end
  if (OFF_COUNT < 1 || OFF_COUNT > (2**CNT_W) - 1) begin : g_bad_off
    $fatal(1, "rpsc_input_filter: OFF_COUNT does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_COUNT - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_COUNT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    LOW, RISE_QUAL, HIGH, FALL_QUAL
  } st_e;

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   s;
  st_e              state_q [NCH];
  st_e              state_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   abort;
  logic [NCH-1:0]   filt_d;
  logic [NCH-1:0]   glitch_d;
  logic [NCH-1:0]   filt_q;
  logic [NCH-1:0]   rise_q;
  logic [NCH-1:0]   fall_q;
  logic [NCH-1:0]   glitch_q;
  logic             any_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // An abort takes priority over reaching the limit on the same cycle.
  always_comb begin
    abort = '0;
    filt_d = '0;
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        LOW: begin
          if (s[k]) begin
            if (ON_COUNT == 1) begin
              state_d[k] = HIGH;
            end else begin
              state_d[k] = RISE_QUAL;
              cnt_d[k]   = ONE;
            end
          end
        end
        RISE_QUAL: begin
          if (!s[k]) begin
            state_d[k] = LOW;
            cnt_d[k]   = '0;
            abort[k]   = 1'b1;
          end else if (cnt_q[k] == ON_LIM) begin
            state_d[k] = HIGH;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + ONE;
          end
        end
        HIGH: begin
          if (!s[k]) begin
            if (OFF_COUNT == 1) begin
              state_d[k] = LOW;
            end else begin
              state_d[k] = FALL_QUAL;
              cnt_d[k]   = ONE;
            end
          end
        end
        FALL_QUAL: begin
          if (s[k]) begin
            state_d[k] = HIGH;
            cnt_d[k]   = '0;
            abort[k]   = 1'b1;
          end else if (cnt_q[k] == OFF_LIM) begin
            state_d[k] = LOW;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + ONE;
          end
        end
        default: begin
          state_d[k] = LOW;
          cnt_d[k]   = '0;
        end
      endcase
      filt_d[k] = (state_d[k] == HIGH) || (state_d[k] == FALL_QUAL);
    end
  end

  assign glitch_d = (glitch_q & ~{NCH{clr_glitch}}) | abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= LOW;
        cnt_q[k]   <= '0;
      end
      filt_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      filt_q   <= filt_d;
      rise_q   <= filt_d & ~filt_q;
      fall_q   <= ~filt_d & filt_q;
      glitch_q <= glitch_d;
      any_q    <= |glitch_d;
    end
  end

  assign filt_out    = filt_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign glitch_flag = glitch_q;
  assign any_glitch  = any_q;

endmodule

// File: tb/tb_rpsc_input_filter.sv
// Scoreboard bench for rpsc_input_filter: expected edge/glitch events are
// queued by the stimulus and matched by an independent monitor.
module tb_rpsc_input_filter;

  localparam int NCH = 4;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] raw_in;
  logic           clr_glitch;
  logic [NCH-1:0] filt_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;
  logic [NCH-1:0] glitch_flag;
  logic           any_glitch;

  rpsc_input_filter #(
    .NCH(NCH), .SYNC_STAGES(2), .ON_COUNT(16),
    .OFF_COUNT(8), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .clr_glitch(clr_glitch), .filt_out(filt_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .glitch_flag(glitch_flag), .any_glitch(any_glitch)
  );

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  c;
  int  d;
  logic [NCH-1:0] prev_g = '0;
  ev_t e_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int kind, int ch, int at);
    ev_t e;
    e.kind = kind;
    e.ch = ch;
    e.cyc = at;
    sb.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // kind: 0 = rise_pulse, 1 = fall_pulse, 2 = glitch_flag set
  always @(posedge clk) begin
    #1;
    for (int kind = 0; kind < 3; kind++) begin
      for (int k = 0; k < NCH; k++) begin
        logic hit;
        hit = (kind == 0) ? rise_pulse[k] :
              (kind == 1) ? fall_pulse[k] :
              (glitch_flag[k] && !prev_g[k]);
        if (hit) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d ch=%0d cyc=%0d",
                     kind, k, cyc);
          end else begin
            e_m = sb.pop_front();
            if (e_m.kind != kind || e_m.ch != k || e_m.cyc != cyc) begin
              errors++;
              $display("FAIL event: got kind=%0d ch=%0d cyc=%0d want kind=%0d ch=%0d cyc=%0d",
                       kind, k, cyc, e_m.kind, e_m.ch, e_m.cyc);
            end
          end
        end
      end
    end
    prev_g = glitch_flag;
  end

  initial begin
    reset = 1'b1;
    raw_in = '0;
    clr_glitch = 1'b0;
    #1;
    reset = 1'b0;
    raw_in = 4'b1111;
    tick(3);
    chk("rst_filt", 32'(filt_out), 0);
    chk("rst_rise", 32'(rise_pulse), 0);
    chk("rst_fall", 32'(fall_pulse), 0);
    chk("rst_glitch", 32'(glitch_flag), 0);
    chk("rst_any", 32'(any_glitch), 0);

    reset = 1'b1;
    c = cyc;
    for (int k = 0; k < NCH; k++) push(0, k, c + 18);
    tick(17);
    chk("rel_pre", 32'(filt_out), 0);
    tick(1);
    chk("rel_filt", 32'(filt_out), 32'hF);
    chk("rel_glitch", 32'(glitch_flag), 0);
    raw_in = '0;
    c = cyc;
    for (int k = 0; k < NCH; k++) push(1, k, c + 10);
    tick(9);
    chk("all_fall_pre", 32'(filt_out), 32'hF);
    tick(1);
    chk("all_fall", 32'(filt_out), 0);
    tick(3);

    raw_in[0] = 1'b1;
    c = cyc;
    push(0, 0, c + 18);
    tick(17);
    chk("lat_rise_pre", 32'(filt_out), 0);
    tick(1);
    chk("lat_rise", 32'(filt_out), 32'h1);
    tick(22);
    raw_in[0] = 1'b0;
    c = cyc;
    push(1, 0, c + 10);
    tick(9);
    chk("lat_fall_pre", 32'(filt_out), 32'h1);
    tick(1);
    chk("lat_fall", 32'(filt_out), 0);
    tick(3);

    raw_in[1] = 1'b1;
    c = cyc;
    push(2, 1, c + 13);
    tick(10);
    raw_in[1] = 1'b0;
    tick(2);
    chk("glitch_pre", 32'(glitch_flag), 0);
    tick(1);
    chk("glitch_set", 32'(glitch_flag), 32'h2);
    chk("glitch_any", 32'(any_glitch), 1);
    chk("glitch_filt", 32'(filt_out), 0);
    tick(2);
    clr_glitch = 1'b1;
    tick(1);
    clr_glitch = 1'b0;
    chk("clr_flag", 32'(glitch_flag), 0);
    chk("clr_any", 32'(any_glitch), 0);

    raw_in[2] = 1'b1;
    c = cyc;
    push(2, 2, c + 18);
    tick(15);
    raw_in[2] = 1'b0;
    tick(3);
    chk("p15_filt", 32'(filt_out), 0);
    chk("p15_glitch", 32'(glitch_flag), 32'h4);
    tick(7);
    clr_glitch = 1'b1;
    tick(1);
    clr_glitch = 1'b0;

    raw_in[2] = 1'b1;
    c = cyc;
    push(0, 2, c + 18);
    push(1, 2, c + 26);
    tick(16);
    raw_in[2] = 1'b0;
    tick(2);
    chk("p16_rise", 32'(filt_out), 32'h4);
    tick(8);
    chk("p16_fall", 32'(filt_out), 0);
    tick(3);

    raw_in[2] = 1'b1;
    c = cyc;
    push(0, 2, c + 18);
    tick(25);
    raw_in[2] = 1'b0;
    d = cyc;
    push(2, 2, d + 10);
    tick(7);
    raw_in[2] = 1'b1;
    tick(3);
    chk("low7_filt", 32'(filt_out), 32'h4);
    chk("low7_glitch", 32'(glitch_flag), 32'h4);
    tick(5);
    raw_in[2] = 1'b0;
    d = cyc;
    push(1, 2, d + 10);
    push(0, 2, d + 26);
    tick(8);
    raw_in[2] = 1'b1;
    tick(1);
    chk("low8_pre", 32'(filt_out), 32'h4);
    tick(1);
    chk("low8_fall", 32'(filt_out), 0);
    tick(16);
    chk("low8_rerise", 32'(filt_out), 32'h4);
    raw_in[2] = 1'b0;
    push(1, 2, cyc + 10);
    tick(12);
    clr_glitch = 1'b1;
    tick(1);
    clr_glitch = 1'b0;

    raw_in[3] = 1'b1;
    c = cyc;
    push(2, 3, c + 8);
    tick(5);
    raw_in[3] = 1'b0;
    tick(2);
    chk("coll_pre", 32'(glitch_flag), 0);
    clr_glitch = 1'b1;
    tick(1);
    clr_glitch = 1'b0;
    chk("coll_flag", 32'(glitch_flag), 32'h8);
    chk("coll_any", 32'(any_glitch), 1);
    tick(3);

    raw_in[0] = 1'b1;
    tick(10);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    c = cyc;
    push(0, 0, c + 18);
    tick(17);
    chk("mrst_pre", 32'(filt_out), 0);
    tick(1);
    chk("mrst_filt", 32'(filt_out), 32'h1);
    chk("mrst_glitch", 32'(glitch_flag), 0);
    tick(5);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
